// File: rtl/instruction_fetcher_if.sv
// Program-memory read channel between the instruction fetcher and program memory.
//
// Handshake: the fetcher raises mem_read_valid with mem_read_address and holds
// both stable until memory answers. Memory answers by pulsing mem_read_ready
// for one cycle, with mem_read_data valid in that same cycle. The fetcher drops
// valid on the edge where it samples ready=1. A request is never withdrawn
// except by reset, and memory must then discard the outstanding read.
interface instruction_fetcher_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 32
);
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;

  // Fetcher side: issues requests, consumes responses.
  modport master (
    output mem_read_valid,
    output mem_read_address,
    input  mem_read_ready,
    input  mem_read_data
  );

  // Memory side: accepts requests, returns data.
  modport slave (
    input  mem_read_valid,
    input  mem_read_address,
    output mem_read_ready,
    output mem_read_data
  );
endinterface

// File: rtl/instruction_fetcher.sv
// Per-core instruction fetcher.
// When the scheduler reports FETCH, the fetcher reads the word at current_pc from
// program memory, latches it into instruction, and reports FETCHED. It returns to
// IDLE when the scheduler moves on to DECODE.
// Optional feature: define FETCH_LAST_PC_CACHE_EN to add a single-entry cache
// holding the last fetched word. A hit skips memory entirely, and the
// cache_hit_count output reports the number of hits.
module instruction_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  instruction_fetcher_if.master            mem,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
`ifdef FETCH_LAST_PC_CACHE_EN
  ,
  output logic [15:0]                      cache_hit_count
`endif
);

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_FETCHING = 3'b001,
    ST_FETCHED  = 3'b010
  } fetch_state_t;

  fetch_state_t                     state_q;
  logic                             mem_valid_q;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_addr_q;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q;

`ifdef FETCH_LAST_PC_CACHE_EN
  logic                             cached_valid;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] cached_pc;
  logic [PROGRAM_MEM_DATA_BITS-1:0] cached_word;
  logic [15:0]                      hit_count_q;
  logic                             cache_hit;

  // A hit needs a valid entry whose address matches the PC being fetched.
  assign cache_hit       = cached_valid && (current_pc == cached_pc);
  assign cache_hit_count = hit_count_q;
`endif

  // The state register doubles as the scheduler-visible status and the debug view.
  assign fetcher_state        = state_q;
  assign mem.mem_read_valid   = mem_valid_q;
  assign mem.mem_read_address = mem_addr_q;
  assign instruction          = instr_q;

  // Fetch FSM: issue the request, wait for ready, hold the word until DECODE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      instr_q     <= '0;
`ifdef FETCH_LAST_PC_CACHE_EN
      cached_valid <= 1'b0;
      cached_pc    <= '0;
      cached_word  <= '0;
      hit_count_q  <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (core_state == CORE_FETCH) begin
`ifdef FETCH_LAST_PC_CACHE_EN
            if (cache_hit) begin
              // Serve straight from the cache; memory never sees a request.
              instr_q <= cached_word;
              state_q <= ST_FETCHED;
              if (hit_count_q != 16'hFFFF) begin
                hit_count_q <= hit_count_q + 16'd1;
              end
            end else begin
              mem_valid_q <= 1'b1;
              mem_addr_q  <= current_pc;
              state_q     <= ST_FETCHING;
            end
`else
            mem_valid_q <= 1'b1;
            mem_addr_q  <= current_pc;
            state_q     <= ST_FETCHING;
`endif
          end
        end

        ST_FETCHING: begin
          // The request stays up whatever the scheduler does; only ready ends it.
          if (mem.mem_read_ready) begin
            instr_q     <= mem.mem_read_data;
            mem_valid_q <= 1'b0;
            state_q     <= ST_FETCHED;
`ifdef FETCH_LAST_PC_CACHE_EN
            cached_valid <= 1'b1;
            cached_pc    <= mem_addr_q;
            cached_word  <= mem.mem_read_data;
`endif
          end
        end

        ST_FETCHED: begin
          if (core_state == CORE_DECODE) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          // Illegal encoding: drop any request and restart from IDLE.
          mem_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed testbench for instruction_fetcher.
// Define FETCH_LAST_PC_CACHE_EN to also cover the last-PC cache.
module tb_instruction_fetcher;

  localparam int AW = 8;
  localparam int DW = 32;

  localparam logic [2:0] CORE_IDLE   = 3'b000;
  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  localparam logic [2:0] S_IDLE     = 3'b000;
  localparam logic [2:0] S_FETCHING = 3'b001;
  localparam logic [2:0] S_FETCHED  = 3'b010;

  logic          clk;
  logic          reset;
  logic [2:0]    core_state;
  logic [AW-1:0] current_pc;
  logic [2:0]    fetcher_state;
  logic [DW-1:0] instruction;
`ifdef FETCH_LAST_PC_CACHE_EN
  logic [15:0]   cache_hit_count;
`endif

  int total;
  int bad;

  instruction_fetcher_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) mem_if ();

  instruction_fetcher #(
    .PROGRAM_MEM_ADDR_BITS(AW),
    .PROGRAM_MEM_DATA_BITS(DW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .core_state    (core_state),
    .current_pc    (current_pc),
    .mem           (mem_if),
    .fetcher_state (fetcher_state),
    .instruction   (instruction)
`ifdef FETCH_LAST_PC_CACHE_EN
    ,
    .cache_hit_count (cache_hit_count)
`endif
  );

  // Clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: advance one edge, then settle 1 time unit before driving or sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_core(input string name, input logic [2:0] st, input logic vld,
                            input logic [AW-1:0] addr, input logic [DW-1:0] instr);
    total++;
    if (fetcher_state !== st || mem_if.mem_read_valid !== vld ||
        mem_if.mem_read_address !== addr || instruction !== instr) begin
      bad++;
      $display("FAIL %s: got state=%b valid=%b addr=%h instr=%h, want state=%b valid=%b addr=%h instr=%h",
               name, fetcher_state, mem_if.mem_read_valid, mem_if.mem_read_address,
               instruction, st, vld, addr, instr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    core_state = CORE_IDLE;
    current_pc = '0;
    mem_if.mem_read_ready = 1'b0;
    mem_if.mem_read_data = '0;
    step();
    step();
    check_core("reset_values", S_IDLE, 1'b0, 8'h00, 32'h0);
`ifdef FETCH_LAST_PC_CACHE_EN
    total++;
    if (cache_hit_count !== 16'h0) begin
      bad++;
      $display("FAIL reset_hit_count: got %h want 0000", cache_hit_count);
    end
`endif
    reset = 1'b0;
    step();
    check_core("idle_after_reset", S_IDLE, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic test_min_latency();
    core_state = CORE_FETCH;
    current_pc = 8'h05;
    mem_if.mem_read_ready = 1'b1;
    mem_if.mem_read_data = 32'hDEADBEEF;
    step();
    check_core("min_lat_request", S_FETCHING, 1'b1, 8'h05, 32'h0);
    step();
    check_core("min_lat_fetched", S_FETCHED, 1'b0, 8'h05, 32'hDEADBEEF);
    mem_if.mem_read_ready = 1'b0;
    core_state = CORE_DECODE;
    step();
    check_core("min_lat_decode_idle", S_IDLE, 1'b0, 8'h05, 32'hDEADBEEF);
    core_state = CORE_IDLE;
  endtask

  task automatic test_delayed_ready();
    core_state = CORE_FETCH;
    current_pc = 8'h10;
    mem_if.mem_read_ready = 1'b0;
    mem_if.mem_read_data = 32'h0BAD0BAD;
    step();
    check_core("delay_edge1", S_FETCHING, 1'b1, 8'h10, 32'hDEADBEEF);
    // Scheduler wanders off and the PC moves; the request must stay put.
    core_state = CORE_IDLE;
    current_pc = 8'h3F;
    for (int i = 2; i <= 5; i++) begin
      step();
      check_core($sformatf("delay_edge%0d", i), S_FETCHING, 1'b1, 8'h10, 32'hDEADBEEF);
    end
    mem_if.mem_read_ready = 1'b1;
    mem_if.mem_read_data = 32'hCAFE0010;
    step();
    check_core("delay_fetched_6th", S_FETCHED, 1'b0, 8'h10, 32'hCAFE0010);
    mem_if.mem_read_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    // FETCHED holds under non-DECODE states, even with a stray ready.
    core_state = CORE_FETCH;
    mem_if.mem_read_ready = 1'b1;
    mem_if.mem_read_data = 32'h55555555;
    step();
    check_core("fetched_hold", S_FETCHED, 1'b0, 8'h10, 32'hCAFE0010);
    mem_if.mem_read_ready = 1'b0;
    core_state = CORE_DECODE;
    step();
    check_core("b2b_idle", S_IDLE, 1'b0, 8'h10, 32'hCAFE0010);
    core_state = CORE_FETCH;
    current_pc = 8'h11;
    step();
    check_core("b2b_request", S_FETCHING, 1'b1, 8'h11, 32'hCAFE0010);
    step();
    check_core("b2b_wait", S_FETCHING, 1'b1, 8'h11, 32'hCAFE0010);
    mem_if.mem_read_ready = 1'b1;
    mem_if.mem_read_data = 32'h11112222;
    step();
    check_core("b2b_fetched", S_FETCHED, 1'b0, 8'h11, 32'h11112222);
    mem_if.mem_read_ready = 1'b0;
    core_state = CORE_DECODE;
    step();
    core_state = CORE_IDLE;
  endtask

  task automatic test_reset_mid_fetch();
    core_state = CORE_FETCH;
    current_pc = 8'h20;
    step();
    check_core("rst_mid_request", S_FETCHING, 1'b1, 8'h20, 32'h11112222);
    #2;
    reset = 1'b1;
    #1;
    // Asynchronous clear: well before the next rising edge.
    check_core("rst_mid_async", S_IDLE, 1'b0, 8'h00, 32'h0);
    step();
    reset = 1'b0;
    core_state = CORE_IDLE;
    mem_if.mem_read_ready = 1'b1;
    mem_if.mem_read_data = 32'h99999999;
    step();
    check_core("rst_stray_ready", S_IDLE, 1'b0, 8'h00, 32'h0);
    mem_if.mem_read_ready = 1'b0;
  endtask

  task automatic test_ready_in_idle();
    core_state = CORE_IDLE;
    mem_if.mem_read_ready = 1'b1;
    mem_if.mem_read_data = 32'h00001234;
    step();
    check_core("idle_ready_pulse", S_IDLE, 1'b0, 8'h00, 32'h0);
    mem_if.mem_read_ready = 1'b0;
    step();
    check_core("idle_ready_after", S_IDLE, 1'b0, 8'h00, 32'h0);
  endtask

`ifdef FETCH_LAST_PC_CACHE_EN
  task automatic test_cache();
    logic seen_valid;
    core_state = CORE_FETCH;
    current_pc = 8'h07;
    mem_if.mem_read_ready = 1'b1;
    mem_if.mem_read_data = 32'hA5A50007;
    step();
    check_core("cache_miss_request", S_FETCHING, 1'b1, 8'h07, 32'h0);
    step();
    check_core("cache_miss_fetched", S_FETCHED, 1'b0, 8'h07, 32'hA5A50007);
    mem_if.mem_read_ready = 1'b0;
    mem_if.mem_read_data = 32'hFFFFFFFF;
    core_state = CORE_DECODE;
    step();
    core_state = CORE_FETCH;
    seen_valid = 1'b0;
    @(posedge clk);
    seen_valid = seen_valid | mem_if.mem_read_valid;
    #1;
    seen_valid = seen_valid | mem_if.mem_read_valid;
    check_core("cache_hit_fetched", S_FETCHED, 1'b0, 8'h07, 32'hA5A50007);
    total++;
    if (cache_hit_count !== 16'd1 || seen_valid !== 1'b0) begin
      bad++;
      $display("FAIL cache_hit_count: got count=%0d valid_seen=%b want count=1 valid_seen=0",
               cache_hit_count, seen_valid);
    end
    core_state = CORE_DECODE;
    step();
    core_state = CORE_FETCH;
    current_pc = 8'h08;
    step();
    check_core("cache_other_pc_miss", S_FETCHING, 1'b1, 8'h08, 32'hA5A50007);
    total++;
    if (cache_hit_count !== 16'd1) begin
      bad++;
      $display("FAIL cache_miss_count: got %0d want 1", cache_hit_count);
    end
    mem_if.mem_read_ready = 1'b1;
    mem_if.mem_read_data = 32'h00000008;
    step();
    mem_if.mem_read_ready = 1'b0;
    core_state = CORE_DECODE;
    step();
    core_state = CORE_IDLE;
  endtask
`endif

  // Sequencer and final report
  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_min_latency();
    test_delayed_ready();
    test_back_to_back();
    test_reset_mid_fetch();
    test_ready_in_idle();
`ifdef FETCH_LAST_PC_CACHE_EN
    test_cache();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
